jt10_adpcma_regs: RTL and testbench
===================================

JT10_ADPCMA_REGS -- requirements
Module: jt10_adpcma_regs

Interface
REQ-001 SHALL have these ports (clock and reset first):
- clk  in  1  CPU clock
- rst_n  in  1  reset; asynchronous, active-low
- cen  in  1  666 kHz clock enable
- wr  in  1  single-clk write strobe
- addr  in  8  ADPCM-A register address
- din  in  8  write data
- atl  out  6  total level
- lracl  out  8  L/R/level byte for channel up_lracl
- up_lracl  out  3  lracl target channel; 7 = idle
- addr_in  out  12  {hi[3:0], lo[7:0]} address for up_addr channel
- up_start  out  1  start-address update
- up_end  out  1  end-address update
- up_addr  out  3  channel for up_start/up_end
- aon_cmd  out  8  key command; 0 = idle
- busy  out  1  update window active
- ovf  out  1  sticky overflow; update lost
- dout  out  8  readback data; only when JT10_ADPCMA_RDBACK_EN is defined

Function
REQ-002 Register map SHALL be:
- 0x00: key command
- 0x01: atl <= din[5:0]
- 0x08-0x0D: lracl of channel n = addr[2:0]
- 0x10-0x15: start low
- 0x18-0x1D: start high
- 0x20-0x25: end low
- 0x28-0x2D: end high
- Other addresses SHALL be ignored; so SHALL n > 5.
REQ-003 atl and low-byte writes SHALL take effect on the clk after wr and SHALL NOT generate an update.
REQ-004 Update-generating writes SHALL be 0x00, 0x08-0x0D, 0x18-0x1D and 0x28-0x2D. Each SHALL form an update entry {kind, channel, data}; kind is one of KEY, LR, START, END.
REQ-005 FSM states SHALL be IDLE and WIN.
- IDLE + entry: drive the entry's outputs, load the window counter with WIN_LEN = 36, go to WIN.
- WIN: decrement the counter on each cen.
- At 0 with no pending entry: go to IDLE. At 0 with a pending entry: issue it in the same clk (back-to-back).
REQ-006 In WIN, exactly one update SHALL be driven, per kind:
- KEY: aon_cmd = din.
- LR: up_lracl = ch; lracl = stored byte.
- START: up_start = 1; up_addr = ch; addr_in = {hi[3:0], lo}.
- END: up_end = 1; up_addr = ch; addr_in = {hi[3:0], lo}.
REQ-007 Idle output values SHALL be: aon_cmd = 0, up_lracl = 7, up_start = 0, up_end = 0. up_addr and addr_in SHALL keep their last value.
REQ-008 busy SHALL equal (state == WIN).
REQ-009 An update write in WIN SHALL go to a one-entry pending slot. A write while the slot is full SHALL be dropped and SHALL set ovf. ovf SHALL clear only on reset.
REQ-010 A write on the clk where WIN ends SHALL be treated as a WIN-state write (pending) and issued next.
REQ-011 Latency from wr to outputs SHALL be 1 clk in IDLE.
REQ-012 The hi/lo bytes SHALL be stored per channel. A low-byte write to a channel SHALL NOT alter an update already in flight for that channel.

Reset
REQ-013 Reset SHALL set:
- Registers: all stored bytes 0.
- Outputs: atl = 0, lracl = 0, up_lracl = 7, addr_in = 0, up_start = 0, up_end = 0, up_addr = 0, aon_cmd = 0, busy = 0, ovf = 0, dout = 0.
- Internal: state IDLE, pending slot empty, window counter 0.
REQ-014 Reset during WIN SHALL abort the update and discard the pending entry.

Configuration
REQ-015 JT10_ADPCMA_RDBACK_EN SHALL control readback:
- Defined: dout = stored byte at addr, combinational; unmapped addresses return 0xFF.
- Undefined: there is no dout port and no read mux.

Structure
REQ-016 Package jt10_adpcma_pkg SHALL hold the register address constants, WIN_LEN and the kind enum.
REQ-017 There SHALL be one sub-module, jt10_adpcma_updq, holding the FSM, window counter and pending slot. Register storage SHALL stay in the top module.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Write 0x10=0x34, then 0x18=0x0A -> up_start = 1, up_addr = 0, addr_in = 0xA34 for 36 cen; busy = 1 for the same span; then up_start = 0.
- Write 0x00=0x05 -> aon_cmd = 0x05 for 36 cen, then 0x00. Write 0x00=0x81 -> aon_cmd = 0x81.
- Write 0x0B=0xDF, then during WIN write 0x2B=0x01 -> lracl = 0xDF and up_lracl = 3; then back-to-back up_end = 1, up_addr = 3, addr_in = 0x1xx; ovf = 0.
- Three update writes within one WIN -> third dropped, ovf = 1 and stays 1.
- Assert rst_n mid-WIN with a pending entry -> all outputs at reset values; nothing issued after release.
- With JT10_ADPCMA_RDBACK_EN: write 0x21=0x5A -> read addr 0x21 gives 0x5A; read addr 0x40 gives 0xFF.

Source files
------------

// File: rtl/jt10_adpcma_pkg.sv
// Shared definitions for the ADPCM-A register block: register addresses,
// update window length, and the update-entry record passed to the update queue.
package jt10_adpcma_pkg;

   localparam int NCH     = 6;
   localparam int WIN_LEN = 36;

   localparam logic [7:0] A_KEY = 8'h00;
   localparam logic [7:0] A_ATL = 8'h01;
   localparam logic [7:0] A_LR  = 8'h08;
   localparam logic [7:0] A_SLO = 8'h10;
   localparam logic [7:0] A_SHI = 8'h18;
   localparam logic [7:0] A_ELO = 8'h20;
   localparam logic [7:0] A_EHI = 8'h28;

   localparam logic [2:0] LR_IDLE = 3'd7;

   typedef enum logic [1:0] {
      KIND_KEY,
      KIND_LR,
      KIND_START,
      KIND_END
   } kind_e;

   // One update as seen by the sound core; data is captured at write time
   // so later register writes cannot disturb an update already queued.
   typedef struct packed {
      kind_e       kind;
      logic [2:0]  ch;
      logic [11:0] data;
   } upd_t;

endpackage

// File: rtl/jt10_adpcma_updq.sv
// Update sequencer: drives one update at a time for a window of WIN_LEN
// clock enables, with a single pending slot behind it. Sticky ovf flags
// any update that found the slot occupied.
module jt10_adpcma_updq
   import jt10_adpcma_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cen,
   input  logic        entry_v,
   input  upd_t        entry,
   output logic [7:0]  aon_cmd,
   output logic [7:0]  lracl,
   output logic [2:0]  up_lracl,
   output logic [11:0] addr_in,
   output logic        up_start,
   output logic        up_end,
   output logic [2:0]  up_addr,
   output logic        busy,
   output logic        ovf
);

   typedef enum logic {S_IDLE, S_WIN} state_e;

   localparam logic [5:0] WIN_CNT = 6'(WIN_LEN);

   state_e      state, state_nx;
   logic [5:0]  cnt, cnt_nx;
   logic        pend_v, pend_v_nx;
   upd_t        pend, pend_nx;
   logic        win_end, issue, issue_pend, issue_new;
   logic        to_slot, slot_free, drop;
   upd_t        issue_ent;

   // Decide what gets issued this clk, where an incoming write goes, and
   // the next state; a write on the window's last clk lands in the slot.
   always_comb begin
      win_end    = (state == S_WIN) && cen && (cnt == 6'd1);
      issue_pend = pend_v && ((state == S_IDLE) || win_end);
      issue_new  = entry_v && (state == S_IDLE) && !pend_v;
      issue      = issue_pend || issue_new;
      issue_ent  = issue_pend ? pend : entry;
      to_slot    = entry_v && !issue_new;
      slot_free  = !pend_v || issue_pend;
      drop       = to_slot && !slot_free;
      pend_v_nx  = pend_v;
      pend_nx    = pend;
      if (to_slot && slot_free) begin
         pend_v_nx = 1'b1;
         pend_nx   = entry;
      end else if (issue_pend) begin
         pend_v_nx = 1'b0;
      end
      state_nx = state;
      cnt_nx   = cnt;
      if (issue) begin
         state_nx = S_WIN;
         cnt_nx   = WIN_CNT;
      end else if (win_end) begin
         state_nx = S_IDLE;
         cnt_nx   = '0;
      end else if ((state == S_WIN) && cen) begin
         cnt_nx = cnt - 6'd1;
      end
   end

   // State, window counter and pending slot registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         cnt    <= '0;
         pend_v <= 1'b0;
         pend   <= '0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         pend_v <= pend_v_nx;
         pend   <= pend_nx;
      end
   end

   // Registered update outputs: one kind active per window, idle values
   // between windows; up_addr, addr_in and lracl hold their last value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aon_cmd  <= '0;
         lracl    <= '0;
         up_lracl <= LR_IDLE;
         addr_in  <= '0;
         up_start <= 1'b0;
         up_end   <= 1'b0;
         up_addr  <= '0;
      end else if (issue) begin
         aon_cmd  <= '0;
         up_lracl <= LR_IDLE;
         up_start <= 1'b0;
         up_end   <= 1'b0;
         case (issue_ent.kind)
            KIND_KEY:   aon_cmd <= issue_ent.data[7:0];
            KIND_LR: begin
               up_lracl <= issue_ent.ch;
               lracl    <= issue_ent.data[7:0];
            end
            KIND_START: begin
               up_start <= 1'b1;
               up_addr  <= issue_ent.ch;
               addr_in  <= issue_ent.data;
            end
            KIND_END: begin
               up_end  <= 1'b1;
               up_addr <= issue_ent.ch;
               addr_in <= issue_ent.data;
            end
         endcase
      end else if (win_end) begin
         aon_cmd  <= '0;
         up_lracl <= LR_IDLE;
         up_start <= 1'b0;
         up_end   <= 1'b0;
      end
   end

   // Sticky overflow: set whenever an update is lost, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    ovf <= 1'b0;
      else if (drop) ovf <= 1'b1;
   end

   assign busy = (state == S_WIN);

endmodule

// File: rtl/jt10_adpcma_regs.sv
// ADPCM-A register file: decodes CPU writes, keeps per-channel address
// bytes, and hands update entries to jt10_adpcma_updq.
// Optional readback port enabled by defining JT10_ADPCMA_RDBACK_EN.
module jt10_adpcma_regs
   import jt10_adpcma_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cen,
   input  logic        wr,
   input  logic [7:0]  addr,
   input  logic [7:0]  din,
   output logic [5:0]  atl,
   output logic [7:0]  lracl,
   output logic [2:0]  up_lracl,
   output logic [11:0] addr_in,
   output logic        up_start,
   output logic        up_end,
   output logic [2:0]  up_addr,
   output logic [7:0]  aon_cmd,
   output logic        busy,
   output logic        ovf
`ifdef JT10_ADPCMA_RDBACK_EN
   ,
   output logic [7:0]  dout
`endif
);

   logic [4:0] grp;
   logic [2:0] ch;
   logic       ch_ok;
   logic [7:0] slo_r [NCH];
   logic [7:0] elo_r [NCH];
   logic       entry_v;
   upd_t       entry;

   assign grp   = addr[7:3];
   assign ch    = addr[2:0];
   assign ch_ok = (ch <= 3'd5);

   // Low address bytes feed the update entries and are always kept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) begin
            slo_r[i] <= '0;
            elo_r[i] <= '0;
         end
      end else if (wr && ch_ok) begin
         if (grp == A_SLO[7:3]) slo_r[ch] <= din;
         if (grp == A_ELO[7:3]) elo_r[ch] <= din;
      end
   end

   // Total level register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     atl <= '0;
      else if (wr && (addr == A_ATL)) atl <= din[5:0];
   end

   // Build an update entry for writes that generate one; the address is
   // completed with the channel's current low byte at write time.
   always_comb begin
      entry_v = 1'b0;
      entry   = '0;
      if (wr) begin
         if (addr == A_KEY) begin
            entry_v    = 1'b1;
            entry.kind = KIND_KEY;
            entry.data = {4'h0, din};
         end else if (ch_ok && (grp == A_LR[7:3])) begin
            entry_v    = 1'b1;
            entry.kind = KIND_LR;
            entry.ch   = ch;
            entry.data = {4'h0, din};
         end else if (ch_ok && (grp == A_SHI[7:3])) begin
            entry_v    = 1'b1;
            entry.kind = KIND_START;
            entry.ch   = ch;
            entry.data = {din[3:0], slo_r[ch]};
         end else if (ch_ok && (grp == A_EHI[7:3])) begin
            entry_v    = 1'b1;
            entry.kind = KIND_END;
            entry.ch   = ch;
            entry.data = {din[3:0], elo_r[ch]};
         end
      end
   end

`ifdef JT10_ADPCMA_RDBACK_EN
   logic [7:0] key_r;
   logic [7:0] lr_r  [NCH];
   logic [7:0] shi_r [NCH];
   logic [7:0] ehi_r [NCH];

   // Bytes only visible through readback: key, L/R/level and high bytes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_r <= '0;
         for (int i = 0; i < NCH; i++) begin
            lr_r[i]  <= '0;
            shi_r[i] <= '0;
            ehi_r[i] <= '0;
         end
      end else if (wr) begin
         if (addr == A_KEY) key_r <= din;
         if (ch_ok && (grp == A_LR[7:3]))  lr_r[ch]  <= din;
         if (ch_ok && (grp == A_SHI[7:3])) shi_r[ch] <= din;
         if (ch_ok && (grp == A_EHI[7:3])) ehi_r[ch] <= din;
      end
   end

   // Combinational read mux; unmapped addresses read as 0xFF.
   always_comb begin
      dout = 8'hFF;
      if (!rst_n)              dout = 8'h00;
      else if (addr == A_KEY)  dout = key_r;
      else if (addr == A_ATL)  dout = {2'b00, atl};
      else if (ch_ok) begin
         if (grp == A_LR[7:3])  dout = lr_r[ch];
         if (grp == A_SLO[7:3]) dout = slo_r[ch];
         if (grp == A_SHI[7:3]) dout = shi_r[ch];
         if (grp == A_ELO[7:3]) dout = elo_r[ch];
         if (grp == A_EHI[7:3]) dout = ehi_r[ch];
      end
   end
`endif

   jt10_adpcma_updq u_updq (
      .clk      (clk),
      .rst_n    (rst_n),
      .cen      (cen),
      .entry_v  (entry_v),
      .entry    (entry),
      .aon_cmd  (aon_cmd),
      .lracl    (lracl),
      .up_lracl (up_lracl),
      .addr_in  (addr_in),
      .up_start (up_start),
      .up_end   (up_end),
      .up_addr  (up_addr),
      .busy     (busy),
      .ovf      (ovf)
   );

endmodule

// File: tb/tb_jt10_adpcma_regs.sv
// Directed bench for jt10_adpcma_regs with a queue of expected updates.
// Readback checks are included when JT10_ADPCMA_RDBACK_EN is defined.
module tb_jt10_adpcma_regs;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cen = 1'b0;
   logic        wr = 1'b0;
   logic [7:0]  addr = '0;
   logic [7:0]  din = '0;
   logic [5:0]  atl;
   logic [7:0]  lracl;
   logic [2:0]  up_lracl;
   logic [11:0] addr_in;
   logic        up_start;
   logic        up_end;
   logic [2:0]  up_addr;
   logic [7:0]  aon_cmd;
   logic        busy;
   logic        ovf;
`ifdef JT10_ADPCMA_RDBACK_EN
   logic [7:0]  dout;
`endif

   typedef struct packed {
      logic [7:0]  aon;
      logic [2:0]  upl;
      logic [7:0]  lr;
      logic        us;
      logic        ue;
      logic [2:0]  ua;
      logic [11:0] ai;
   } obs_t;

   int   total = 0;
   int   bad = 0;
   int   cenSince = 0;
   int   cenDiv = 0;
   obs_t q[$];
   obs_t mLast = '0;
   logic [7:0] mSlo [6];
   logic [7:0] mElo [6];

   jt10_adpcma_regs dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cen      (cen),
      .wr       (wr),
      .addr     (addr),
      .din      (din),
      .atl      (atl),
      .lracl    (lracl),
      .up_lracl (up_lracl),
      .addr_in  (addr_in),
      .up_start (up_start),
      .up_end   (up_end),
      .up_addr  (up_addr),
      .aon_cmd  (aon_cmd),
      .busy     (busy),
      .ovf      (ovf)
`ifdef JT10_ADPCMA_RDBACK_EN
      ,
      .dout     (dout)
`endif
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Clock enable every fourth clk, changed on the falling edge.
   always @(negedge clk) begin
      cenDiv = (cenDiv == 3) ? 0 : cenDiv + 1;
      cen = (cenDiv == 0);
   end

   function automatic obs_t sampleObs();
      return {aon_cmd, up_lracl, lracl, up_start, up_end, up_addr, addr_in};
   endfunction

   function automatic obs_t idleObs();
      obs_t e;
      e     = '0;
      e.upl = 3'd7;
      e.lr  = mLast.lr;
      e.ua  = mLast.ua;
      e.ai  = mLast.ai;
      return e;
   endfunction

   task automatic modelReset();
      mLast = '0;
      for (int i = 0; i < 6; i++) begin
         mSlo[i] = '0;
         mElo[i] = '0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (cen) cenSince++;
      #1;
   endtask

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("[TB] FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   task automatic checkOutput(input string tag);
      obs_t e;
      if (q.size() == 0) begin
         checkVal({tag, " queue"}, 64'd0, 64'd1);
      end else begin
         e = q.pop_front();
         checkVal(tag, 64'(sampleObs()), 64'(e));
      end
   endtask

   // Model a register write, queue the update it should produce, drive it.
   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] d, input bit expectIssue);
      obs_t e;
      int   n;
      e = idleObs();
      n = int'(a[2:0]);
      case (a[7:3])
         5'h00: if (a == 8'h00) e.aon = d;
         5'h01: if (n < 6) begin e.upl = 3'(n); e.lr = d; end
         5'h02: if (n < 6) mSlo[n] = d;
         5'h03: if (n < 6) begin e.us = 1'b1; e.ua = 3'(n); e.ai = {d[3:0], mSlo[n]}; end
         5'h04: if (n < 6) mElo[n] = d;
         5'h05: if (n < 6) begin e.ue = 1'b1; e.ua = 3'(n); e.ai = {d[3:0], mElo[n]}; end
         default: ;
      endcase
      if (expectIssue) begin
         q.push_back(e);
         mLast.lr = e.lr;
         mLast.ua = e.ua;
         mLast.ai = e.ai;
      end
      addr = a;
      din  = d;
      wr   = 1'b1;
      tick();
      wr   = 1'b0;
   endtask

   // Follow the current window to its end, outputs and busy held throughout.
   task automatic waitWindowEnd(input string tag);
      obs_t w;
      bit   spanBad;
      int   k;
      w = sampleObs();
      spanBad = 1'b0;
      k = 0;
      while (cenSince < 36 && k < 2000) begin
         if (sampleObs() !== w || busy !== 1'b1) spanBad = 1'b1;
         tick();
         k++;
      end
      checkVal({tag, " span"}, 64'(spanBad), 64'd0);
      checkVal({tag, " cens"}, 64'(cenSince), 64'd36);
   endtask

   initial begin
      bit idleBad;
      modelReset();
      repeat (3) tick();
      checkVal("reset obs", 64'(sampleObs()), 64'(idleObs()));
      checkVal("reset atl", 64'(atl), 64'd0);
      checkVal("reset busy", 64'(busy), 64'd0);
      checkVal("reset ovf", 64'(ovf), 64'd0);
`ifdef JT10_ADPCMA_RDBACK_EN
      checkVal("reset dout", 64'(dout), 64'd0);
`endif
      rst_n = 1'b1;
      tick();

      // Ignored writes: channel 6 and an unmapped address.
      applyStimulus(8'h0E, 8'h55, 1'b0);
      applyStimulus(8'h30, 8'h12, 1'b0);
      checkVal("ignored busy", 64'(busy), 64'd0);
      checkVal("ignored obs", 64'(sampleObs()), 64'(idleObs()));

      // Start address for channel 0, low byte changed mid-window.
      applyStimulus(8'h10, 8'h34, 1'b0);
      checkVal("lo busy", 64'(busy), 64'd0);
      applyStimulus(8'h18, 8'h0A, 1'b1);
      cenSince = 0;
      checkOutput("start ch0");
      checkVal("start busy", 64'(busy), 64'd1);
      applyStimulus(8'h10, 8'hFF, 1'b0);
      checkVal("start inflight", 64'(addr_in), 64'hA34);
      waitWindowEnd("start");
      checkVal("start idle", 64'(sampleObs()), 64'(idleObs()));
      checkVal("start busy end", 64'(busy), 64'd0);

      // Total level keeps the low six bits.
      applyStimulus(8'h01, 8'hEA, 1'b0);
      checkVal("atl", 64'(atl), 64'h2A);
      checkVal("atl busy", 64'(busy), 64'd0);

      // Key commands.
      applyStimulus(8'h00, 8'h05, 1'b1);
      cenSince = 0;
      checkOutput("key 05");
      waitWindowEnd("key 05");
      checkVal("key idle", 64'(sampleObs()), 64'(idleObs()));
      applyStimulus(8'h00, 8'h81, 1'b1);
      cenSince = 0;
      checkOutput("key 81");
      waitWindowEnd("key 81");

      // L/R on channel 3, then back-to-back end address.
      applyStimulus(8'h0B, 8'hDF, 1'b1);
      cenSince = 0;
      checkOutput("lr ch3");
      repeat (5) tick();
      applyStimulus(8'h2B, 8'h01, 1'b1);
      waitWindowEnd("lr ch3");
      checkOutput("end ch3 b2b");
      checkVal("b2b busy", 64'(busy), 64'd1);
      checkVal("b2b ovf", 64'(ovf), 64'd0);
      cenSince = 0;
      waitWindowEnd("end ch3");
      checkVal("end idle", 64'(sampleObs()), 64'(idleObs()));

      // Three updates in one window: the third is lost.
      applyStimulus(8'h00, 8'h11, 1'b1);
      cenSince = 0;
      checkOutput("ovf first");
      applyStimulus(8'h00, 8'h22, 1'b1);
      applyStimulus(8'h00, 8'h33, 1'b0);
      checkVal("ovf set", 64'(ovf), 64'd1);
      waitWindowEnd("ovf first");
      checkOutput("ovf second");
      cenSince = 0;
      waitWindowEnd("ovf second");
      checkVal("ovf idle", 64'(sampleObs()), 64'(idleObs()));
      checkVal("ovf sticky", 64'(ovf), 64'd1);
      checkVal("ovf queue", 64'(q.size()), 64'd0);

      // Reset in the middle of a window with an entry pending.
      applyStimulus(8'h1C, 8'h07, 1'b1);
      cenSince = 0;
      checkOutput("pre-reset start");
      applyStimulus(8'h00, 8'h44, 1'b1);
      repeat (4) tick();
      rst_n = 1'b0;
      #1;
      q.delete();
      modelReset();
      checkVal("midreset obs", 64'(sampleObs()), 64'(idleObs()));
      checkVal("midreset busy", 64'(busy), 64'd0);
      checkVal("midreset ovf", 64'(ovf), 64'd0);
      checkVal("midreset atl", 64'(atl), 64'd0);
      repeat (3) tick();
      rst_n = 1'b1;
      idleBad = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (busy !== 1'b0 || sampleObs() !== idleObs()) idleBad = 1'b1;
      end
      checkVal("after reset quiet", 64'(idleBad), 64'd0);

`ifdef JT10_ADPCMA_RDBACK_EN
      applyStimulus(8'h21, 8'h5A, 1'b0);
      addr = 8'h21;
      #1;
      checkVal("read 21", 64'(dout), 64'h5A);
      addr = 8'h40;
      #1;
      checkVal("read 40", 64'(dout), 64'hFF);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
